// File: rtl/uart_tx_packet.sv
// Packet UART transmitter: sends up to MAX_BYTES latched bytes as back-to-back 8-bit frames,
// with optional parity, one or two stop bits and selectable byte order.
module uart_tx_packet #(
    parameter int CLOCKS_PER_BIT = 10,
    parameter int MAX_BYTES      = 14,
    parameter int PARITY_EN      = 0,
    parameter int PARITY_ODD     = 0,
    parameter int STOP_BITS      = 1,
    parameter int BYTE_ORDER     = 0
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    input  logic                   i_txBegin,
    input  logic [8*MAX_BYTES-1:0] i_txData,
    input  logic [7:0]             i_txDataLength,
    input  logic                   i_abort,
    output logic                   o_txBusy,
    output logic                   o_txSerial,
    output logic                   o_txDone,
    output logic                   o_txAborted,
    output logic                   o_lenError
);

    localparam int             CW        = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [7:0]     MAX_LEN   = 8'(MAX_BYTES);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic           PAR_INIT  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_bitCnt;
    logic [2:0]             r_bitIdx;
    logic                   r_stopCnt;
    logic [7:0]             r_byteCnt;
    logic [7:0]             r_len;
    logic [8*MAX_BYTES-1:0] r_data;
    logic [7:0]             r_shift;
    logic                   r_parity;

    logic [7:0] w_lenClamp;
    logic [7:0] w_firstIdx;
    logic [7:0] w_nextIdx;
    logic [7:0] w_firstByte;
    logic [7:0] w_nextByte;
    logic       w_bitEnd;
    logic       w_lastByte;
    logic       w_active;

    // Mux by comparison so an out-of-range index yields zero instead of a bad slice.
    function automatic logic [7:0] pick_byte(input logic [8*MAX_BYTES-1:0] data,
                                             input logic [7:0] idx);
        logic [7:0] b;
        b = '0;
        for (int unsigned k = 0; k < MAX_BYTES; k++) begin
            if (idx == 8'(k)) b = data[8*k +: 8];
        end
        return b;
    endfunction

    assign w_lenClamp  = (i_txDataLength > MAX_LEN) ? MAX_LEN : i_txDataLength;
    assign w_firstIdx  = (BYTE_ORDER != 0) ? 8'd0 : w_lenClamp - 8'd1;
    assign w_nextIdx   = (BYTE_ORDER != 0) ? r_byteCnt + 8'd1 : r_len - r_byteCnt - 8'd2;
    assign w_firstByte = pick_byte(i_txData, w_firstIdx);
    assign w_nextByte  = pick_byte(r_data, w_nextIdx);
    assign w_bitEnd    = (r_bitCnt == BIT_LAST);
    assign w_lastByte  = (r_byteCnt == r_len - 8'd1);
    assign w_active    = (r_state == S_START) || (r_state == S_DATA) ||
                         (r_state == S_PARITY) || (r_state == S_STOP);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_bitCnt    <= '0;
            r_bitIdx    <= '0;
            r_stopCnt   <= 1'b0;
            r_byteCnt   <= '0;
            r_len       <= '0;
            r_data      <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            o_txBusy    <= 1'b0;
            o_txSerial  <= 1'b1;
            o_txDone    <= 1'b0;
            o_txAborted <= 1'b0;
            o_lenError  <= 1'b0;
        end else begin
            o_txDone    <= 1'b0;
            o_txAborted <= 1'b0;
            o_lenError  <= 1'b0;
            if (i_abort && w_active) begin
                r_state     <= S_IDLE;
                r_bitCnt    <= '0;
                o_txSerial  <= 1'b1;
                o_txBusy    <= 1'b0;
                o_txAborted <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_txBegin) begin
                            r_data     <= i_txData;
                            r_len      <= w_lenClamp;
                            r_byteCnt  <= '0;
                            r_bitCnt   <= '0;
                            r_bitIdx   <= '0;
                            r_stopCnt  <= 1'b0;
                            o_lenError <= (i_txDataLength > MAX_LEN);
                            if (w_lenClamp == 8'd0) begin
                                r_state  <= S_DONE;
                                o_txDone <= 1'b1;
                            end else begin
                                r_state    <= S_START;
                                o_txBusy   <= 1'b1;
                                o_txSerial <= 1'b0;
                                r_shift    <= w_firstByte;
                                r_parity   <= (^w_firstByte) ^ PAR_INIT;
                            end
                        end
                    end
                    S_START: begin
                        if (w_bitEnd) begin
                            r_bitCnt   <= '0;
                            r_bitIdx   <= '0;
                            r_state    <= S_DATA;
                            o_txSerial <= r_shift[0];
                        end else begin
                            r_bitCnt <= r_bitCnt + CW'(1);
                        end
                    end
                    S_DATA: begin
                        if (w_bitEnd) begin
                            r_bitCnt <= '0;
                            if (r_bitIdx == 3'd7) begin
                                if (PARITY_EN != 0) begin
                                    r_state    <= S_PARITY;
                                    o_txSerial <= r_parity;
                                end else begin
                                    r_state    <= S_STOP;
                                    r_stopCnt  <= 1'b0;
                                    o_txSerial <= 1'b1;
                                end
                            end else begin
                                r_bitIdx   <= r_bitIdx + 3'd1;
                                r_shift    <= r_shift >> 1;
                                o_txSerial <= r_shift[1];
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + CW'(1);
                        end
                    end
                    S_PARITY: begin
                        if (w_bitEnd) begin
                            r_bitCnt   <= '0;
                            r_stopCnt  <= 1'b0;
                            r_state    <= S_STOP;
                            o_txSerial <= 1'b1;
                        end else begin
                            r_bitCnt <= r_bitCnt + CW'(1);
                        end
                    end
                    S_STOP: begin
                        if (w_bitEnd) begin
                            r_bitCnt <= '0;
                            if (r_stopCnt == STOP_LAST) begin
                                if (w_lastByte) begin
                                    r_state    <= S_DONE;
                                    o_txBusy   <= 1'b0;
                                    o_txDone   <= 1'b1;
                                    o_txSerial <= 1'b1;
                                end else begin
                                    // Next start bit follows the final stop cycle directly.
                                    r_byteCnt  <= r_byteCnt + 8'd1;
                                    r_shift    <= w_nextByte;
                                    r_parity   <= (^w_nextByte) ^ PAR_INIT;
                                    r_state    <= S_START;
                                    o_txSerial <= 1'b0;
                                end
                            end else begin
                                r_stopCnt <= 1'b1;
                            end
                        end else begin
                            r_bitCnt <= r_bitCnt + CW'(1);
                        end
                    end
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_packet.sv
// Bench for uart_tx_packet: four parameter variants driven in lockstep, frames decoded
// from the serial line and scored against queued expected bytes.
module tb_uart_tx_packet;

    localparam int CPB = 4;
    localparam int ND  = 4;
    localparam int BO [ND] = '{0, 1, 0, 1};
    localparam int PE [ND] = '{0, 0, 1, 1};
    localparam int OD [ND] = '{0, 0, 0, 1};
    localparam int ST [ND] = '{1, 1, 2, 1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_txBegin;
    logic [31:0] i_txData;
    logic [7:0]  i_txDataLength;
    logic        i_abort;
    logic [ND-1:0] ser, busy, done, abrt, lerr;

    logic [7:0] expq [ND][$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_packet #(.CLOCKS_PER_BIT(CPB), .MAX_BYTES(4), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(1), .BYTE_ORDER(0)) u_d0 (
        .i_clock(clk), .i_reset_n(rst_n), .i_txBegin(i_txBegin), .i_txData(i_txData),
        .i_txDataLength(i_txDataLength), .i_abort(i_abort), .o_txBusy(busy[0]),
        .o_txSerial(ser[0]), .o_txDone(done[0]), .o_txAborted(abrt[0]), .o_lenError(lerr[0]));

    uart_tx_packet #(.CLOCKS_PER_BIT(CPB), .MAX_BYTES(4), .PARITY_EN(0), .PARITY_ODD(0),
                     .STOP_BITS(1), .BYTE_ORDER(1)) u_d1 (
        .i_clock(clk), .i_reset_n(rst_n), .i_txBegin(i_txBegin), .i_txData(i_txData),
        .i_txDataLength(i_txDataLength), .i_abort(i_abort), .o_txBusy(busy[1]),
        .o_txSerial(ser[1]), .o_txDone(done[1]), .o_txAborted(abrt[1]), .o_lenError(lerr[1]));

    uart_tx_packet #(.CLOCKS_PER_BIT(CPB), .MAX_BYTES(4), .PARITY_EN(1), .PARITY_ODD(0),
                     .STOP_BITS(2), .BYTE_ORDER(0)) u_d2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_txBegin(i_txBegin), .i_txData(i_txData),
        .i_txDataLength(i_txDataLength), .i_abort(i_abort), .o_txBusy(busy[2]),
        .o_txSerial(ser[2]), .o_txDone(done[2]), .o_txAborted(abrt[2]), .o_lenError(lerr[2]));

    uart_tx_packet #(.CLOCKS_PER_BIT(CPB), .MAX_BYTES(4), .PARITY_EN(1), .PARITY_ODD(1),
                     .STOP_BITS(1), .BYTE_ORDER(1)) u_d3 (
        .i_clock(clk), .i_reset_n(rst_n), .i_txBegin(i_txBegin), .i_txData(i_txData),
        .i_txDataLength(i_txDataLength), .i_abort(i_abort), .o_txBusy(busy[3]),
        .o_txSerial(ser[3]), .o_txDone(done[3]), .o_txAborted(abrt[3]), .o_lenError(lerr[3]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Decodes one DUT's line; every cycle of a bit must hold the bit's value.
    task automatic mon(input int d);
        logic [11:0] fr;
        logic [7:0]  e;
        bit          bail, bad;
        int          nb;
        nb = 10 + PE[d] + ST[d] - 1;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && ser[d] === 1'b0) begin
                bail = 0;
                bad  = 0;
                fr   = '1;
                for (int i = 0; i < nb && !bail; i++) begin
                    for (int c = 0; c < CPB && !bail; c++) begin
                        if (!(i == 0 && c == 0)) @(negedge clk);
                        if (rst_n !== 1'b1 || abrt[d] === 1'b1) bail = 1;
                        else if (c == 0) fr[i] = ser[d];
                        else if (ser[d] !== fr[i]) bad = 1;
                    end
                end
                if (!bail) begin
                    check($sformatf("d%0d_frame_expected", d), 32'(expq[d].size() != 0), 1);
                    if (expq[d].size() != 0) begin
                        e = expq[d].pop_front();
                        check($sformatf("d%0d_data", d), 32'(fr[8:1]), 32'(e));
                        if (PE[d] != 0)
                            check($sformatf("d%0d_parity", d), 32'(fr[9]), 32'((^e) ^ OD[d][0]));
                        check($sformatf("d%0d_stop", d), 32'(fr[nb-1]), 1);
                        if (ST[d] == 2) check($sformatf("d%0d_stop2", d), 32'(fr[nb-2]), 1);
                        check($sformatf("d%0d_bit_width", d), 32'(bad), 0);
                    end
                end
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);
    initial mon(3);

    task automatic send(input logic [31:0] data, input logic [7:0] len,
                        input int abort_k, input int hold);
        int lc, last, idx, nb, expb;
        int bc [ND], dn [ND], dk [ND], ab [ND], le [ND], lk [ND], low [ND];
        lc = (len > 8'd4) ? 4 : int'(len);
        for (int d = 0; d < ND; d++) begin
            for (int j = 0; j < lc; j++) begin
                idx = (BO[d] != 0) ? j : lc - 1 - j;
                expq[d].push_back(data[8*idx +: 8]);
            end
            bc[d] = 0; dn[d] = 0; dk[d] = 0; ab[d] = 0; le[d] = 0; lk[d] = 0; low[d] = 0;
        end
        @(negedge clk);
        i_txData       = data;
        i_txDataLength = len;
        i_txBegin      = 1'b1;
        last = (abort_k != 0) ? abort_k + 1 : lc * 12 * CPB + 4;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                if (busy[d]) bc[d]++;
                if (done[d]) begin dn[d]++; dk[d] = k; end
                if (abrt[d]) ab[d]++;
                if (lerr[d]) begin le[d]++; lk[d] = k; end
                if (!busy[d] && ser[d] !== 1'b1) low[d]++;
            end
            if (k == 1) begin
                i_txData       = ~data;
                i_txDataLength = 8'd3;
            end
            i_txBegin = (k <= hold);
            i_abort   = (abort_k != 0 && k == abort_k);
        end
        i_txBegin = 1'b0;
        i_abort   = 1'b0;
        for (int d = 0; d < ND; d++) begin
            nb   = 10 + PE[d] + ST[d] - 1;
            expb = (abort_k != 0) ? abort_k : lc * nb * CPB;
            check($sformatf("d%0d_busy_cycles", d), bc[d], expb);
            check($sformatf("d%0d_done_count", d), dn[d], (abort_k != 0) ? 0 : 1);
            if (abort_k == 0) check($sformatf("d%0d_done_cycle", d), dk[d], expb + 1);
            check($sformatf("d%0d_abort_count", d), ab[d], (abort_k != 0) ? 1 : 0);
            check($sformatf("d%0d_lenerr_count", d), le[d], (len > 8'd4) ? 1 : 0);
            if (len > 8'd4) check($sformatf("d%0d_lenerr_cycle", d), lk[d], 1);
            check($sformatf("d%0d_idle_line", d), low[d], 0);
            if (abort_k != 0) expq[d].delete();
            else check($sformatf("d%0d_frames_left", d), expq[d].size(), 0);
        end
    endtask

    // L=0 with begin and abort held: accepted, ignored in DONE, accepted again in IDLE.
    task automatic zero_len_gap();
        logic [5:0] dv [ND];
        int bc [ND], ab [ND], low [ND];
        for (int d = 0; d < ND; d++) begin dv[d] = '0; bc[d] = 0; ab[d] = 0; low[d] = 0; end
        @(negedge clk);
        i_txData       = 32'hDEADBEEF;
        i_txDataLength = 8'd0;
        i_txBegin      = 1'b1;
        i_abort        = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                dv[d][k-1] = done[d];
                if (busy[d]) bc[d]++;
                if (abrt[d]) ab[d]++;
                if (ser[d] !== 1'b1) low[d]++;
            end
            if (k == 3) begin
                i_txBegin = 1'b0;
                i_abort   = 1'b0;
            end
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_gap_done", d), 32'(dv[d]), 32'h05);
            check($sformatf("d%0d_gap_busy", d), bc[d], 0);
            check($sformatf("d%0d_gap_abort", d), ab[d], 0);
            check($sformatf("d%0d_gap_line", d), low[d], 0);
        end
    endtask

    task automatic mid_reset();
        int act [ND];
        @(negedge clk);
        i_txData       = 32'h0F1E2D3C;
        i_txDataLength = 8'd3;
        i_txBegin      = 1'b1;
        @(negedge clk);
        i_txBegin = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_rst_serial", d), 32'(ser[d]), 1);
            check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 0);
            act[d] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) if (done[d] || abrt[d]) act[d]++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++)
                if (done[d] || abrt[d] || busy[d] || lerr[d] || ser[d] !== 1'b1) act[d]++;
        end
        for (int d = 0; d < ND; d++) check($sformatf("d%0d_rst_quiet", d), act[d], 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        i_txBegin      = 1'b0;
        i_txData       = '0;
        i_txDataLength = '0;
        i_abort        = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < ND; d++) begin
            check($sformatf("d%0d_reset_serial", d), 32'(ser[d]), 1);
            check($sformatf("d%0d_reset_busy", d), 32'(busy[d]), 0);
            check($sformatf("d%0d_reset_done", d), 32'(done[d]), 0);
            check($sformatf("d%0d_reset_abort", d), 32'(abrt[d]), 0);
            check($sformatf("d%0d_reset_lenerr", d), 32'(lerr[d]), 0);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(32'h41424344, 8'd2, 0, 0);
        send(32'h00000007, 8'd1, 0, 0);
        send(32'h41424344, 8'd9, 0, 3);
        send(32'hA5C30FF0, 8'd4, 0, 0);
        zero_len_gap();
        send(32'h12345678, 8'd3, 10, 0);
        send(32'h9E8100FF, 8'd2, 0, 0);
        for (int r = 0; r < 4; r++) send($urandom, 8'($urandom_range(0, 6)), 0, 0);
        mid_reset();
        send(32'hC0FFEE11, 8'd3, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_packet.md
UART_TX_PACKET -- requirements
Module: uart_tx_packet

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BIT, default 10, clock cycles per serial bit (legal range >= 2).
REQ-002 SHALL have parameter MAX_BYTES, default 14, capacity of the packet buffer in bytes (legal range 1-255).
REQ-003 SHALL have parameter PARITY_EN, default 0, 1 inserts one parity bit after the data bits.
REQ-004 SHALL have parameter PARITY_ODD, default 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
REQ-005 SHALL have parameter STOP_BITS, default 1, number of stop bits (legal values 1 or 2).
REQ-006 SHALL have parameter BYTE_ORDER, default 0, 0 = byte index L-1 sent first, descending to 0; 1 = byte index 0 sent first, ascending to L-1.
REQ-007 SHALL use one clock; reset is asynchronous and active-low: i_clock  input  1  rising-edge clock.
REQ-008 i_reset_n  input  1  asynchronous active-low reset.
REQ-009 i_txBegin  input  1  start request, sampled only in IDLE.
REQ-010 i_txData  input  8*MAX_BYTES  packet payload; byte k = bits [8k+7:8k].
REQ-011 i_txDataLength  input  8  requested byte count L.
REQ-012 i_abort  input  1  abandon the current packet.
REQ-013 o_txBusy  output  1  packet in progress.
REQ-014 o_txSerial  output  1  serial line, idles high.
REQ-015 o_txDone  output  1  one-cycle pulse on normal completion.
REQ-016 o_txAborted  output  1  one-cycle pulse on abort.
REQ-017 o_lenError  output  1  one-cycle pulse when L > MAX_BYTES.

Function
REQ-018 States: IDLE, START, DATA, PARITY, STOP, DONE; PARITY is never entered when PARITY_EN=0.
REQ-019 Acceptance at edge N (IDLE, i_txBegin=1): SHALL latch i_txData and L into internal registers; later changes to the inputs SHALL have no effect.
REQ-020 If L > MAX_BYTES, SHALL clamp L to MAX_BYTES and pulse o_lenError during cycle N+1.
REQ-021 If L = 0, SHALL produce no serial activity, keep o_txBusy=0, and pulse o_txDone during cycle N+1.
REQ-022 For L >= 1, o_txBusy SHALL be 1 from cycle N+1 and o_txSerial SHALL drive the start bit (0) from cycle N+1.
REQ-023 Each bit SHALL last exactly CLOCKS_PER_BIT cycles; bits within a frame are sent in this order: start, 8 data bits LSB first, optional parity, then STOP_BITS stop bits (1).
REQ-024 Parity SHALL make the total number of ones over the data bits plus the parity bit even (PARITY_ODD=0) or odd (PARITY_ODD=1).
REQ-025 Consecutive frames SHALL be back-to-back, with the next start bit immediately following the last stop-bit cycle.
REQ-026 Total busy time SHALL be L*(10+PARITY_EN+STOP_BITS-1)*CLOCKS_PER_BIT cycles.
REQ-027 In the cycle after the last stop-bit cycle (DONE), o_txBusy SHALL be 0, o_txDone SHALL be 1 for one cycle, and the state SHALL then return to IDLE.
REQ-028 A new i_txBegin SHALL be accepted in the DONE cycle's following IDLE cycle, giving a minimum 1-cycle high gap between packets.
REQ-029 i_txBegin SHALL be ignored while busy or in DONE, with no queuing.
REQ-030 If i_abort=1 while busy, o_txSerial SHALL go to 1 at the next edge, the state SHALL go to IDLE, o_txBusy SHALL go to 0, and o_txAborted SHALL pulse for one cycle; o_txDone SHALL not pulse.
REQ-031 i_abort SHALL be ignored in IDLE and DONE; in IDLE, a simultaneous i_txBegin is accepted.
REQ-032 The bit-cycle counter width SHALL be $clog2(CLOCKS_PER_BIT); the byte counter SHALL be 8 bits; all index arithmetic SHALL stay within 8*MAX_BYTES.

Reset
REQ-033 While i_reset_n=0: state=IDLE, o_txSerial=1, o_txBusy=0, o_txDone=0, o_txAborted=0, o_lenError=0, and all counters cleared.
REQ-034 Reset asserted mid-frame SHALL immediately force o_txSerial=1 with no done or abort pulse; operation resumes from IDLE on the first edge after release.

Verification
REQ-035 CPB=4, MAX=4, defaults, i_txData=0x41424344, L=2 -> frames 0x43 then 0x44; busy for 80 cycles; o_txDone at N+81.
REQ-036 Same configuration with BYTE_ORDER=1 -> frames 0x44 then 0x43; same timing.
REQ-037 PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2, byte 0x07 -> bits 0,1,1,1,0,0,0,0,0,1(parity),1,1; 12*CPB cycles.
REQ-038 L=9 with MAX=4 -> o_lenError at N+1; 4 frames sent; then o_txDone.
REQ-039 L=0 -> o_txDone at N+1; o_txSerial stays 1 and o_txBusy stays 0 throughout.
REQ-040 i_abort during the second data bit -> o_txSerial=1 next cycle, one o_txAborted pulse, no o_txDone; a new i_txBegin two cycles later is accepted and completes normally.
